// File: rtl/bram_pingpong_ctrl_if.sv
// Bus bundle for bram_pingpong_ctrl: input stream, BRAM port A/B, output stream.
// Ports: s_* input stream, *_A write port, *_B read port, m_* output stream,
// bank_full flags, drop_cnt (only with BRAM_PINGPONG_DROP_EN).
// The slave modport is the controller's view; master is the surrounding logic.
interface bram_pingpong_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              WE_A;
    logic [10:0]       ADDR_A;
    logic [DATA_W-1:0] DIN_A;
    logic              EN_B;
    logic [10:0]       ADDR_B;
    logic [DATA_W-1:0] DOUT_B;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;
    logic [1:0]        bank_full;
`ifdef BRAM_PINGPONG_DROP_EN
    logic [15:0]       drop_cnt;
`endif

    modport slave (
        input  s_valid, s_data, DOUT_B, m_ready,
        output s_ready, WE_A, ADDR_A, DIN_A, EN_B, ADDR_B,
        output m_valid, m_data, m_last, bank_full
`ifdef BRAM_PINGPONG_DROP_EN
        , output drop_cnt
`endif
    );

    modport master (
        output s_valid, s_data, DOUT_B, m_ready,
        input  s_ready, WE_A, ADDR_A, DIN_A, EN_B, ADDR_B,
        input  m_valid, m_data, m_last, bank_full
`ifdef BRAM_PINGPONG_DROP_EN
        , input drop_cnt
`endif
    );
endinterface

// File: rtl/bram_pingpong_ctrl.sv
// Ping-pong controller for a 2048-word frame BRAM split into two 1024-word banks.
// Ports: CLK, rst (sync, active-high), bus (slave modport): stream in -> port A,
// port B -> stream out, bank_full. Macro BRAM_PINGPONG_DROP_EN drops words on full.
module bram_pingpong_ctrl #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 1024
) (
    input  logic                  CLK,
    input  logic                  rst,
    bram_pingpong_ctrl_if.slave   bus
);
    localparam logic [9:0] LAST = 10'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} rd_state_e;

    logic              wr_bank_q, wr_bank_d;
    logic [9:0]        wr_cnt_q, wr_cnt_d;
    logic [1:0]        full_q, full_d;
    logic              we_a_q, we_a_d;
    logic [10:0]       addr_a_q, addr_a_d;
    logic [DATA_W-1:0] din_a_q, din_a_d;
    logic              accept, set_full, release_bank;

    rd_state_e         state_q, state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [9:0]        rd_cnt_q, rd_cnt_d;
    logic              en_b_q, en_b_d;
    logic [10:0]       addr_b_q, addr_b_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_last_q, m_last_d;

    // A write only lands in a bank the reader does not own.
    assign accept = bus.s_valid && !rst && !full_q[wr_bank_q];

`ifdef BRAM_PINGPONG_DROP_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign bus.s_ready = !rst;
    assign bus.drop_cnt = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.s_valid && full_q[wr_bank_q] && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end
`else
    assign bus.s_ready = !rst && !full_q[wr_bank_q];
`endif

    always_comb begin
        we_a_d    = accept;
        addr_a_d  = addr_a_q;
        din_a_d   = din_a_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        set_full  = 1'b0;
        if (accept) begin
            addr_a_d = {wr_bank_q, wr_cnt_q};
            din_a_d  = bus.s_data;
            if (wr_cnt_q == LAST) begin
                wr_cnt_d  = '0;
                wr_bank_d = ~wr_bank_q;
                set_full  = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 10'd1;
            end
        end
    end

    // Set and clear always hit different banks, so ordering is irrelevant.
    always_comb begin
        full_d = full_q;
        if (set_full)     full_d[wr_bank_q] = 1'b1;
        if (release_bank) full_d[rd_bank_q] = 1'b0;
    end

    // EN_B/ADDR_B are registered, so they are loaded on the edge entering ISSUE.
    always_comb begin
        state_d      = state_q;
        rd_bank_d    = rd_bank_q;
        rd_cnt_d     = rd_cnt_q;
        en_b_d       = 1'b0;
        addr_b_d     = addr_b_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        release_bank = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_cnt_d = '0;
                    en_b_d   = 1'b1;
                    addr_b_d = {rd_bank_q, 10'd0};
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                m_data_d  = bus.DOUT_B;
                m_valid_d = 1'b1;
                m_last_d  = (rd_cnt_q == LAST);
                state_d   = OUT;
            end
            OUT: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q) begin
                        release_bank = 1'b1;
                        rd_bank_d    = ~rd_bank_q;
                        state_d      = IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 10'd1;
                        en_b_d   = 1'b1;
                        addr_b_d = {rd_bank_q, 10'(rd_cnt_q + 10'd1)};
                        state_d  = ISSUE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            full_q    <= '0;
            we_a_q    <= 1'b0;
            addr_a_q  <= '0;
            din_a_q   <= '0;
            state_q   <= IDLE;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            en_b_q    <= 1'b0;
            addr_b_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            full_q    <= full_d;
            we_a_q    <= we_a_d;
            addr_a_q  <= addr_a_d;
            din_a_q   <= din_a_d;
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            en_b_q    <= en_b_d;
            addr_b_q  <= addr_b_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign bus.WE_A      = we_a_q;
    assign bus.ADDR_A    = addr_a_q;
    assign bus.DIN_A     = din_a_q;
    assign bus.EN_B      = en_b_q;
    assign bus.ADDR_B    = addr_b_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_last    = m_last_q;
    assign bus.bank_full = full_q;
endmodule
